// File: rtl/writeback_stage_pkg.sv
// Shared core definitions for the MEM/WB boundary: widths, writeback-select and load-type
// encodings, and the slot payload handed from the memory stage.
package writeback_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CNT_W    = 64;
  localparam int unsigned RD_W     = 5;
  localparam int unsigned WB_SEL_W = 2;
  localparam int unsigned F3_W     = 3;

  localparam logic [WB_SEL_W-1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [WB_SEL_W-1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [WB_SEL_W-1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [RD_W-1:0]     rd;
    logic                reg_we;
    logic [WB_SEL_W-1:0] wb_sel;
    logic [XLEN-1:0]     alu_result;
    logic [F3_W-1:0]     funct3;
    logic [XLEN-1:0]     rdata;
  } wb_slot_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM -> WB bus plus the register-file write port, forwarding tap and status outputs.
interface writeback_stage_if;
  import writeback_stage_pkg::*;

  logic                hold;
  logic                mem_valid;
  logic [XLEN-1:0]     mem_pc;
  logic [RD_W-1:0]     mem_rd;
  logic                mem_reg_we;
  logic [WB_SEL_W-1:0] mem_wb_sel;
  logic [XLEN-1:0]     mem_alu_result;
  logic [F3_W-1:0]     mem_funct3;
  logic [XLEN-1:0]     dmem_rdata;

  logic [RD_W-1:0]     rf_addr_rd;
  logic [XLEN-1:0]     rf_data_rd;
  logic                rf_write_enable;
  logic                fwd_valid;
  logic [RD_W-1:0]     fwd_rd;
  logic [XLEN-1:0]     fwd_data;
  logic                wb_misaligned;
  logic [CNT_W-1:0]    instret;

  modport master (
    output hold, mem_valid, mem_pc, mem_rd, mem_reg_we, mem_wb_sel,
           mem_alu_result, mem_funct3, dmem_rdata,
    input  rf_addr_rd, rf_data_rd, rf_write_enable, fwd_valid, fwd_rd,
           fwd_data, wb_misaligned, instret
  );

  modport slave (
    input  hold, mem_valid, mem_pc, mem_rd, mem_reg_we, mem_wb_sel,
           mem_alu_result, mem_funct3, dmem_rdata,
    output rf_addr_rd, rf_data_rd, rf_write_enable, fwd_valid, fwd_rd,
           fwd_data, wb_misaligned, instret
  );

endinterface

// File: rtl/writeback_stage_load_formatter.sv
// Extracts and extends the addressed byte/half of an aligned load word; flags misalignment.
module writeback_stage_load_formatter
  import writeback_stage_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = 8'(rdata >> {off, 3'b000});
    half_v     = 16'(rdata >> {off[1], 4'b0000});
    data       = rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH: begin
        data       = {{(XLEN-16){half_v[15]}}, half_v};
        misaligned = off[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_v};
        misaligned = off[0];
      end
      // LW and every undefined encoding take the whole word
      default: misaligned = (off != 2'b00);
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback mux: formats loads, drives the register-file
// write port, exposes a same-cycle forwarding tap and counts retired instructions.
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  writeback_stage_if.slave wb
);

  wb_slot_t         slot;
  wb_slot_t         mem_slot;
  logic             written;
  logic [CNT_W-1:0] retired;

  logic [XLEN-1:0]  fmt_data;
  logic             fmt_misaligned;
  logic [XLEN-1:0]  result;
  logic             is_load;
  logic             misaligned_load;
  logic             dest_ok;

  always_comb begin
    mem_slot.valid      = wb.mem_valid;
    mem_slot.pc         = wb.mem_pc;
    mem_slot.rd         = wb.mem_rd;
    mem_slot.reg_we     = wb.mem_reg_we;
    mem_slot.wb_sel     = wb.mem_wb_sel;
    mem_slot.alu_result = wb.mem_alu_result;
    mem_slot.funct3     = wb.mem_funct3;
    mem_slot.rdata      = wb.dmem_rdata;
  end

  // Slot capture; a held valid instruction is marked written after its first cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot    <= '0;
      written <= 1'b0;
      retired <= '0;
    end else begin
      if (slot.valid && !written) retired <= retired + CNT_W'(1);
      if (!wb.hold) begin
        slot    <= mem_slot;
        written <= 1'b0;
      end else if (slot.valid) begin
        written <= 1'b1;
      end
    end
  end

  writeback_stage_load_formatter u_fmt (
    .funct3     (slot.funct3),
    .off        (slot.alu_result[1:0]),
    .rdata      (slot.rdata),
    .data       (fmt_data),
    .misaligned (fmt_misaligned)
  );

  // Reserved select falls through to the ALU path
  always_comb begin
    case (slot.wb_sel)
      WB_SEL_LOAD: result = fmt_data;
      WB_SEL_PC4:  result = slot.pc + XLEN'(4);
      default:     result = slot.alu_result;
    endcase
  end

  assign is_load         = (slot.wb_sel == WB_SEL_LOAD);
  assign misaligned_load = is_load && fmt_misaligned;
  assign dest_ok         = slot.valid && slot.reg_we && (slot.rd != '0) && !misaligned_load;

  assign wb.rf_write_enable = dest_ok && !written;
  assign wb.rf_addr_rd      = slot.valid ? slot.rd : '0;
  assign wb.rf_data_rd      = slot.valid ? result : '0;

  // Forwarding stays live for the whole hold because the rf only reads on address change
  assign wb.fwd_valid       = dest_ok;
  assign wb.fwd_rd          = slot.valid ? slot.rd : '0;
  assign wb.fwd_data        = slot.valid ? result : '0;

  assign wb.wb_misaligned   = slot.valid && misaligned_load && !written;
  assign wb.instret         = retired;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed bench for writeback_stage against a slot-level reference model.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  writeback_stage_if bus ();

  writeback_stage dut (
    .clock   (clock),
    .reset_n (reset_n),
    .wb      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the instruction sitting in WB and whether it has had its write cycle
  bit              m_valid;
  logic [31:0]     m_pc, m_alu, m_rdata;
  logic [4:0]      m_rd;
  bit              m_we;
  logic [1:0]      m_sel;
  logic [2:0]      m_f3;
  bit              m_first;
  longint unsigned m_instret;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off,
                                           input logic [31:0] w, output bit mis);
    int unsigned b, h;
    b   = (w >> (off * 8)) & 32'hFF;
    h   = (w >> ((off / 2) * 16)) & 32'hFFFF;
    mis = 1'b0;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: return b;
      3'd1: begin mis = (off % 2) != 0; return (h >= 32768) ? h + 32'hFFFF_0000 : h; end
      3'd5: begin mis = (off % 2) != 0; return h; end
      default: begin mis = (off != 0); return w; end
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_first = 1'b1; m_instret = 0;
    m_pc = '0; m_alu = '0; m_rdata = '0; m_rd = '0; m_we = 1'b0; m_sel = '0; m_f3 = '0;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [4:0] rd, input bit we,
                       input logic [1:0] sel, input logic [31:0] alu, input logic [2:0] f3,
                       input logic [31:0] rdata, input bit hold);
    bus.mem_valid = v; bus.mem_pc = pc; bus.mem_rd = rd; bus.mem_reg_we = we;
    bus.mem_wb_sel = sel; bus.mem_alu_result = alu; bus.mem_funct3 = f3;
    bus.dmem_rdata = rdata; bus.hold = hold;
  endtask

  task automatic compare();
    logic [31:0] res;
    bit lmis, mis, e_fwd;
    res = ref_load(m_f3, int'(m_alu % 4), m_rdata, lmis);
    mis = (m_sel == 2'd1) && lmis;
    if (m_sel == 2'd2) res = m_pc + 32'd4;
    else if (m_sel != 2'd1) res = m_alu;
    e_fwd = m_valid && m_we && (m_rd != 0) && !mis;
    check("rf_we", 64'(bus.rf_write_enable), 64'(e_fwd && m_first));
    check("fwd_valid", 64'(bus.fwd_valid), 64'(e_fwd));
    check("misaligned", 64'(bus.wb_misaligned), 64'(m_valid && mis && m_first));
    check("instret", bus.instret, m_instret);
    if (m_valid) begin
      check("rf_addr", 64'(bus.rf_addr_rd), 64'(m_rd));
      check("rf_data", 64'(bus.rf_data_rd), 64'(res));
    end
    if (e_fwd) begin
      check("fwd_rd", 64'(bus.fwd_rd), 64'(m_rd));
      check("fwd_data", 64'(bus.fwd_data), 64'(res));
    end
  endtask

  // One clock: advance the model on the edge, then compare 1 time unit later
  task automatic step();
    @(posedge clock);
    if (m_valid && m_first) m_instret++;
    if (!bus.hold) begin
      m_valid = bus.mem_valid; m_pc = bus.mem_pc; m_rd = bus.mem_rd; m_we = bus.mem_reg_we;
      m_sel = bus.mem_wb_sel; m_alu = bus.mem_alu_result; m_f3 = bus.mem_funct3;
      m_rdata = bus.dmem_rdata; m_first = 1'b1;
    end else if (m_valid) begin
      m_first = 1'b0;
    end
    #1;
    compare();
  endtask

  task automatic bubble();
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic dir_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] exp);
    drive(1'b1, 32'h100, 5'd9, 1'b1, 2'd1, 32'h2000 | 32'(off), f3, 32'h80FF_7F01, 1'b0);
    step();
    check("dir_load", 64'(bus.rf_data_rd), 64'(exp));
  endtask

  initial begin
    reset_n = 1'b0;
    bubble();
    model_reset();
    #12;
    check("rst_rf_we", 64'(bus.rf_write_enable), 64'd0);
    check("rst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
    check("rst_misaligned", 64'(bus.wb_misaligned), 64'd0);
    check("rst_instret", bus.instret, 64'd0);
    check("rst_rf_addr", 64'(bus.rf_addr_rd), 64'd0);
    check("rst_rf_data", 64'(bus.rf_data_rd), 64'd0);
    check("rst_fwd_data", 64'(bus.fwd_data), 64'd0);
    reset_n = 1'b1;

    // ALU writeback, then instret reaches 1 on the following edge
    drive(1'b1, 32'h40, 5'd5, 1'b1, 2'd0, 32'h1234, 3'd0, 32'hDEAD_BEEF, 1'b0);
    step();
    check("alu_we", 64'(bus.rf_write_enable), 64'd1);
    check("alu_data", 64'(bus.rf_data_rd), 64'h1234);
    bubble();
    step();
    check("alu_instret", bus.instret, 64'd1);

    dir_load(3'd0, 2'd1, 32'h0000_007F);
    dir_load(3'd0, 2'd2, 32'hFFFF_FFFF);
    dir_load(3'd4, 2'd3, 32'h0000_0080);
    dir_load(3'd1, 2'd2, 32'hFFFF_80FF);
    dir_load(3'd5, 2'd0, 32'h0000_7F01);

    // rd = x0 never writes but retires
    drive(1'b1, 32'h80, 5'd0, 1'b1, 2'd0, 32'h55, 3'd0, '0, 1'b0);
    step();

    // LW held for three cycles writes once
    drive(1'b1, 32'h84, 5'd7, 1'b1, 2'd1, 32'h3000, 3'd2, 32'hCAFE_F00D, 1'b0);
    step();
    bus.hold = 1'b1;
    repeat (3) step();
    check("hold_fwd", 64'(bus.fwd_valid), 64'd1);
    bus.hold = 1'b0;
    bubble();
    step();

    // Misaligned LW and LH: pulse, no write
    drive(1'b1, 32'h88, 5'd3, 1'b1, 2'd1, 32'h3002, 3'd2, 32'h1111_2222, 1'b0);
    step();
    check("lw_mis", 64'(bus.wb_misaligned), 64'd1);
    drive(1'b1, 32'h8C, 5'd3, 1'b1, 2'd1, 32'h3003, 3'd1, 32'h1111_2222, 1'b0);
    step();
    check("lh_mis", 64'(bus.wb_misaligned), 64'd1);
    bubble();
    step();

    // Asynchronous reset between edges
    drive(1'b1, 32'h90, 5'd4, 1'b1, 2'd0, 32'h77, 3'd0, '0, 1'b0);
    step();
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_we", 64'(bus.rf_write_enable), 64'd0);
    check("rst_mid_instret", bus.instret, 64'd0);
    model_reset();
    #1 reset_n = 1'b1;

    // JAL at the top of the address space wraps PC+4
    drive(1'b1, 32'hFFFF_FFFC, 5'd1, 1'b1, 2'd2, 32'h0, 3'd0, '0, 1'b0);
    step();
    check("jal_wrap", 64'(bus.rf_data_rd), 64'd0);

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 8), $urandom, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom),
            1'($urandom), 2'($urandom), $urandom, 3'($urandom), $urandom,
            ($urandom_range(0, 4) == 0));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
